// File: rtl/fetch_align_buffer.sv
// Instruction fetch front end: fetches aligned words and re-aligns them into a
// halfword queue so 16-bit and misaligned 32-bit instructions reach decode.
module fetch_align_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_compressed_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [31:0] RESET_FETCH = {RESET_PC[31:2], 2'b00};
    localparam logic [31:0] RESET_PC_HW = {RESET_PC[31:1], 1'b0};

    state_t      state_reg;
    logic [47:0] queue_reg;
    logic [1:0]  hw_cnt_reg;
    logic [31:0] pc_reg;
    logic [31:0] fetch_addr_reg;
    logic        discard_low_reg;
    logic        drop_resp_reg;

    logic        is_rvc;
    logic        pop;
    logic        append;
    logic [1:0]  pop_n;
    logic [1:0]  app_n;
    logic [1:0]  cnt_pop;
    logic [1:0]  cnt_next;
    logic [47:0] queue_shift;
    logic [47:0] queue_next;

    assign is_rvc             = (queue_reg[1:0] != 2'b11);
    assign instr_valid_o      = is_rvc ? (hw_cnt_reg != 2'd0) : (hw_cnt_reg >= 2'd2);
    assign instr_compressed_o = (hw_cnt_reg != 2'd0) && is_rvc;
    assign instr_o            = (hw_cnt_reg == 2'd0) ? 32'h0 :
                                is_rvc ? {16'h0, queue_reg[15:0]} : queue_reg[31:0];
    assign instr_pc_o         = pc_reg;
    assign imem_req_o         = (state_reg == REQ);
    assign imem_addr_o        = fetch_addr_reg;

    // A consume coinciding with a flush is ignored, as is any response being dropped.
    assign pop      = instr_valid_o && instr_ready_i && !flush_i;
    assign pop_n    = !pop ? 2'd0 : (is_rvc ? 2'd1 : 2'd2);
    assign cnt_pop  = hw_cnt_reg - pop_n;
    assign append   = (state_reg == WAIT) && imem_rvalid_i && !drop_resp_reg && !flush_i;
    assign app_n    = !append ? 2'd0 : (discard_low_reg ? 2'd1 : 2'd2);
    assign cnt_next = cnt_pop + app_n;

    assign queue_shift = queue_reg >> {pop_n, 4'b0000};

    // Pop first, then new halfwords land right after the surviving entries.
    for (genvar gi = 0; gi < 3; gi++) begin : gen_slot
        localparam logic [1:0] SLOT = 2'(gi);
        logic [15:0] slot_next;

        always_comb begin
            slot_next = queue_shift[16*gi +: 16];
            if (append && cnt_pop == SLOT) begin
                slot_next = discard_low_reg ? imem_rdata_i[31:16] : imem_rdata_i[15:0];
            end else if (append && !discard_low_reg && (cnt_pop + 2'd1) == SLOT) begin
                slot_next = imem_rdata_i[31:16];
            end
        end

        assign queue_next[16*gi +: 16] = slot_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            queue_reg       <= '0;
            hw_cnt_reg      <= 2'd0;
            pc_reg          <= RESET_PC_HW;
            fetch_addr_reg  <= RESET_FETCH;
            discard_low_reg <= RESET_PC[1];
            drop_resp_reg   <= 1'b0;
        end else if (flush_i) begin
            hw_cnt_reg      <= 2'd0;
            pc_reg          <= {flush_pc_i[31:1], 1'b0};
            fetch_addr_reg  <= {flush_pc_i[31:2], 2'b00};
            discard_low_reg <= flush_pc_i[1];
            case (state_reg)
                WAIT: begin
                    if (imem_rvalid_i) begin
                        state_reg     <= REQ;
                        drop_resp_reg <= 1'b0;
                    end else begin
                        drop_resp_reg <= 1'b1;
                    end
                end
                REQ: begin
                    // A request accepted in this very cycle still returns data; drop it.
                    if (imem_ready_i) begin
                        state_reg     <= WAIT;
                        drop_resp_reg <= 1'b1;
                    end
                end
                default: state_reg <= REQ;
            endcase
        end else begin
            queue_reg  <= queue_next;
            hw_cnt_reg <= cnt_next;
            if (pop) begin
                pc_reg <= pc_reg + {29'd0, pop_n, 1'b0};
            end
            case (state_reg)
                IDLE: begin
                    if (cnt_pop <= 2'd1) begin
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    if (imem_ready_i) begin
                        fetch_addr_reg <= fetch_addr_reg + 32'd4;
                        state_reg      <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        if (drop_resp_reg) begin
                            drop_resp_reg <= 1'b0;
                            state_reg     <= REQ;
                        end else begin
                            discard_low_reg <= 1'b0;
                            state_reg       <= (cnt_next <= 2'd1) ? REQ : IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Bench for fetch_align_buffer: behavioural instruction memory, table of
// fetch vectors and a queue of expected instructions checked at decode.
module tb_fetch_align_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic [31:0] flush_pc_i = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_compressed_o;

    fetch_align_buffer #(.RESET_PC(32'h0000_0000)) dut (
        .clk                (clk),
        .rst                (rst),
        .flush_i            (flush_i),
        .flush_pc_i         (flush_pc_i),
        .imem_req_o         (imem_req_o),
        .imem_addr_o        (imem_addr_o),
        .imem_ready_i       (imem_ready_i),
        .imem_rvalid_i      (imem_rvalid_i),
        .imem_rdata_i       (imem_rdata_i),
        .instr_valid_o      (instr_valid_o),
        .instr_ready_i      (instr_ready_i),
        .instr_o            (instr_o),
        .instr_pc_o         (instr_pc_o),
        .instr_compressed_o (instr_compressed_o)
    );

    always #5 clk = ~clk;

    // Instruction memory: one outstanding request, configurable latency and ready.
    logic [31:0] mem [0:255];
    bit          acc;
    logic [31:0] acc_addr;
    bit          pend;
    int          pend_cnt;
    logic [31:0] pend_addr;
    int          mem_lat = 0;
    bit          mem_rand_ready = 1'b0;
    bit          mem_ready = 1'b1;

    always @(negedge clk) begin
        acc      = imem_req_o && imem_ready_i && !rst;
        acc_addr = imem_addr_o;
    end

    always @(posedge clk) begin
        #1;
        imem_rvalid_i = 1'b0;
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (acc) begin
                pend      = 1'b1;
                pend_cnt  = mem_lat;
                pend_addr = acc_addr;
            end
            if (pend) begin
                if (pend_cnt == 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = mem[pend_addr[9:2]];
                    pend          = 1'b0;
                end else begin
                    pend_cnt = pend_cnt - 1;
                end
            end
        end
        imem_ready_i = mem_rand_ready ? 1'($urandom_range(1, 0)) : mem_ready;
    end

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        c;
    } exp_t;

    typedef struct packed {
        logic [31:0]      start_pc;
        logic [31:0]      w0;
        logic [31:0]      w1;
        logic [1:0]       n;
        logic [2:0][31:0] e_instr;
        logic [2:0][31:0] e_pc;
        logic [2:0]       e_c;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[5];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout want event", name);
    endtask

    function automatic vec_t mk(input logic [31:0] spc, input logic [31:0] w0, input logic [31:0] w1,
                                input logic [1:0] n,
                                input logic [31:0] i0, input logic [31:0] p0, input logic c0,
                                input logic [31:0] i1, input logic [31:0] p1, input logic c1,
                                input logic [31:0] i2, input logic [31:0] p2, input logic c2);
        vec_t v;
        v.start_pc = spc;
        v.w0 = w0;
        v.w1 = w1;
        v.n = n;
        v.e_instr = {i2, i1, i0};
        v.e_pc = {p2, p1, p0};
        v.e_c = {c2, c1, c0};
        return v;
    endfunction

    task automatic push_vec(input vec_t v);
        for (int k = 0; k < int'(v.n); k++) begin
            exp_q.push_back('{instr: v.e_instr[k], pc: v.e_pc[k], c: v.e_c[k]});
        end
    endtask

    task automatic do_flush(input logic [31:0] pc);
        @(posedge clk);
        #1;
        instr_ready_i = 1'b0;
        flush_i = 1'b1;
        flush_pc_i = pc;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
    endtask

    // Consume with random back-pressure until every expected instruction is seen.
    task automatic drain();
        int cyc = 0;
        exp_t e;
        while (exp_q.size() > 0 && cyc < 400) begin
            @(negedge clk);
            if (instr_valid_o && instr_ready_i) begin
                e = exp_q.pop_front();
                $display("xact pc=%h instr=%h c=%b", instr_pc_o, instr_o, instr_compressed_o);
                chk("instr", instr_o, e.instr);
                chk("pc", instr_pc_o, e.pc);
                chk("compressed", {31'd0, instr_compressed_o}, {31'd0, e.c});
            end
            @(posedge clk);
            #1;
            instr_ready_i = (exp_q.size() > 0) ? 1'($urandom_range(1, 0)) : 1'b0;
            cyc++;
        end
        instr_ready_i = 1'b0;
        if (exp_q.size() > 0) begin
            timeout_fail("drain");
            exp_q.delete();
        end
    endtask

    task automatic wait_req(input string name, input logic [31:0] want_addr);
        int cyc = 0;
        @(negedge clk);
        while (!imem_req_o && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!imem_req_o) timeout_fail(name);
        else chk(name, imem_addr_o, want_addr);
    endtask

    initial begin
        logic [31:0] held;
        int cyc;

        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0000_0013;

        vecs[0] = mk(32'h00, 32'h0050_0093, 32'h0000_0013, 2'd2,
                     32'h0050_0093, 32'h00, 1'b0, 32'h0000_0013, 32'h04, 1'b0, 32'h0, 32'h0, 1'b0);
        vecs[1] = mk(32'h10, 32'h4505_4085, 32'h0000_0013, 2'd2,
                     32'h0000_4085, 32'h10, 1'b1, 32'h0000_4505, 32'h12, 1'b1, 32'h0, 32'h0, 1'b0);
        vecs[2] = mk(32'h20, 32'h0093_4085, 32'h1234_0050, 2'd3,
                     32'h0000_4085, 32'h20, 1'b1, 32'h0050_0093, 32'h22, 1'b0, 32'h0000_1234, 32'h26, 1'b1);
        vecs[3] = mk(32'h102, 32'h4085_dead, 32'h0000_0013, 2'd2,
                     32'h0000_4085, 32'h102, 1'b1, 32'h0000_0013, 32'h104, 1'b0, 32'h0, 32'h0, 1'b0);
        vecs[4] = mk(32'h32, 32'h0093_1111, 32'h4505_0050, 2'd2,
                     32'h0050_0093, 32'h32, 1'b0, 32'h0000_4505, 32'h36, 1'b1, 32'h0, 32'h0, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rst_req", {31'd0, imem_req_o}, 32'd0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_comp", {31'd0, instr_compressed_o}, 32'd0);
        chk("rst_pc", instr_pc_o, 32'h0);
        rst = 1'b0;

        // Latency from reset release: req in cycle 1, valid in cycle 3
        @(posedge clk);
        #1;
        chk("lat_req1", {31'd0, imem_req_o}, 32'd1);
        chk("lat_addr1", imem_addr_o, 32'h0);
        @(posedge clk);
        #1;
        chk("lat_valid2", {31'd0, instr_valid_o}, 32'd0);
        @(posedge clk);
        #1;
        chk("lat_valid3", {31'd0, instr_valid_o}, 32'd1);
        chk("lat_instr", instr_o, 32'h0050_0093);

        // Stall with decode blocked: no new requests, output held
        held = instr_o;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_req", {31'd0, imem_req_o}, 32'd0);
            chk("stall_instr", instr_o, held);
        end

        // Consume the addi, then the next request must target 4
        @(posedge clk);
        #1;
        instr_ready_i = 1'b1;
        @(negedge clk);
        $display("xact pc=%h instr=%h c=%b", instr_pc_o, instr_o, instr_compressed_o);
        chk("t1_instr", instr_o, 32'h0050_0093);
        chk("t1_pc", instr_pc_o, 32'h0);
        chk("t1_comp", {31'd0, instr_compressed_o}, 32'd0);
        @(posedge clk);
        #1;
        instr_ready_i = 1'b0;
        wait_req("t1_next_addr", 32'h4);
        exp_q.push_back('{instr: 32'h0000_0013, pc: 32'h4, c: 1'b0});
        drain();

        // Table of redirect vectors with random memory ready and latency
        mem_rand_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            mem[vecs[v].start_pc[9:2]] = vecs[v].w0;
            mem[vecs[v].start_pc[9:2] + 8'd1] = vecs[v].w1;
            mem_lat = $urandom_range(2, 0);
            do_flush(vecs[v].start_pc);
            push_vec(vecs[v]);
            drain();
        end

        // Flush while waiting on a slow response: stale data must be dropped
        mem_rand_ready = 1'b0;
        mem_ready = 1'b1;
        mem_lat = 3;
        mem[16] = 32'h1111_1111;
        do_flush(32'h40);
        cyc = 0;
        @(negedge clk);
        while (!acc && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!acc) timeout_fail("t5_accept");
        do_flush(32'h102);
        wait_req("t5_redirect_addr", 32'h100);
        push_vec(vecs[3]);
        drain();

        // Reset while a request is pending and not accepted
        mem_lat = 0;
        mem_ready = 1'b0;
        do_flush(32'h40);
        repeat (2) @(posedge clk);
        #1;
        chk("t6_pre_req", {31'd0, imem_req_o}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_req", {31'd0, imem_req_o}, 32'd0);
        chk("t6_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("t6_pc", instr_pc_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b1;
        wait_req("t6_refetch_addr", 32'h0);
        push_vec(vecs[0]);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
